// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_pkg                                                         |
// | Purpose  : Shared width codes, LSU state encoding and request checking     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    // Illegal width codes are reported through the misaligned flag as well.
    function automatic logic lsu_req_misaligned(input logic       is_store,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic legal;
        logic unaligned;
        if (is_store)
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        unaligned = (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
                    ((f3 == F3_W) && (off != 2'b00));
        return !legal || unaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lsu_lane_align                                                  |
// | Purpose  : Load lane extraction with extension, and sub-word store merge   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rd_word[7:0];
        case (byte_off)
            2'd0:    w_byte = rd_word[7:0];
            2'd1:    w_byte = rd_word[15:8];
            2'd2:    w_byte = rd_word[23:16];
            default: w_byte = rd_word[31:24];
        endcase
        w_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_data = {24'd0, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   load_data = {16'd0, w_half};
            default: load_data = rd_word;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the old word survives.
    always_comb begin
        merged = rd_word;
        case (funct3[1:0])
            2'b00: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = st_data[7:0];
                    2'd1:    merged[15:8]  = st_data[7:0];
                    2'd2:    merged[23:16] = st_data[7:0];
                    default: merged[31:24] = st_data[7:0];
                endcase
            end
            2'b01: begin
                if (byte_off[1])
                    merged[31:16] = st_data[15:0];
                else
                    merged[15:0]  = st_data[15:0];
            end
            default: merged = st_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : load_store_unit                                                 |
// | Purpose  : Data-memory initiator: loads, stores, sub-word RMW, fault flags |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module load_store_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        access_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] c_MEM_WORDS = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        misaligned_q, misaligned_d;
    logic        access_fault_q, access_fault_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        w_req_mis;
    logic        w_req_af;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_req_mis = lsu_req_misaligned(we, funct3, addr[1:0]);
    assign w_req_af  = !w_req_mis && (addr[31:2] >= c_MEM_WORDS);

    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .byte_off  (off_q),
        .rd_word   (mem_rdata),
        .st_data   (wdata_q),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    always_comb begin
        state_d        = state_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        wdata_d        = wdata_q;
        rdata_d        = rdata_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        misaligned_d   = 1'b0;
        access_fault_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {2'b00, addr[31:2]};
                    // Faulting requests go straight to RESP, so their flags
                    // can be registered right here.
                    if (w_req_mis || w_req_af) begin
                        state_d        = RESP;
                        misaligned_d   = w_req_mis;
                        access_fault_d = w_req_af;
                    end else if (!we) begin
                        state_d = LOAD;
                    end else if (funct3 == F3_W) begin
                        state_d     = STORE;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = w_load_data;
                state_d = RESP;
            end
            STORE:  state_d = RESP;
            RMW_RD: begin
                // mem_wdata_q doubles as the merge register for the write-back.
                mem_wdata_d = w_merged;
                state_d     = RMW_WR;
            end
            RMW_WR: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == RESP);
        mem_read_d  = (state_d == LOAD)  || (state_d == RMW_RD);
        mem_write_d = (state_d == STORE) || (state_d == RMW_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            funct3_q       <= 3'd0;
            off_q          <= 2'd0;
            wdata_q        <= 32'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            misaligned_q   <= 1'b0;
            access_fault_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            rdata_q        <= 32'd0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            misaligned_q   <= misaligned_d;
            access_fault_q <= access_fault_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            rdata_q        <= rdata_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign misaligned   = misaligned_q;
    assign access_fault = access_fault_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_load_store_unit                                              |
// | Purpose  : Directed and randomized checks of load_store_unit vs a model    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, misaligned, access_fault, mem_read, mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        preload = 1'b1;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misaligned(misaligned), .access_fault(access_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Word-indexed data memory; read data is garbage unless MemRead is high.
    logic [31:0] tb_mem [0:MEM_WORDS-1];
    assign mem_rdata = (mem_read && mem_addr < MEM_WORDS) ? tb_mem[mem_addr[5:0]] : 32'hA5A5_5A5A;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_WORDS; i++) tb_mem[i] <= seed_word(i);
        end else if (mem_write && mem_addr < MEM_WORDS) begin
            tb_mem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] ref_rdata;

    int total = 0;
    int bad = 0;

    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_rdata, exp_wdata;
    logic        exp_mis, exp_af;
    int          got_lat, got_rd, got_wr, got_proto;
    logic [31:0] got_rdata, got_wdata;
    logic        got_mis, got_af;

    task automatic ref_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
        logic        legal;
        int          sz, off;
        logic [31:0] widx, word, mask, v;
        legal = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        off   = int'(a[1:0]);
        widx  = a >> 2;
        exp_mis   = !legal || ((a & 32'(sz - 1)) != 0);
        exp_af    = !exp_mis && (widx >= MEM_WORDS);
        exp_rd    = 0;
        exp_wr    = 0;
        exp_wdata = 32'd0;
        if (exp_mis || exp_af) begin
            exp_lat = 1;
        end else if (!w) begin
            word = ref_mem[widx[5:0]];
            v = word >> (8 * off);
            if (sz == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            ref_rdata = v;
            exp_lat = 2;
            exp_rd  = 1;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 32'd1) << (8 * off));
            word = (ref_mem[widx[5:0]] & ~mask) | ((wd << (8 * off)) & mask);
            ref_mem[widx[5:0]] = word;
            exp_wdata = word;
            exp_lat = (sz == 4) ? 2 : 3;
            exp_rd  = (sz == 4) ? 0 : 1;
            exp_wr  = 1;
        end
        exp_rdata = ref_rdata;
    endtask

    // Issue one request from an IDLE negedge; returns at the IDLE negedge after done.
    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic hold);
        ref_access(w, f3, a, wd);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        got_lat = 99; got_rd = 0; got_wr = 0; got_proto = 0;
        got_wdata = 32'd0; got_rdata = 32'hx; got_mis = 1'bx; got_af = 1'bx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1 && !hold) req = 1'b0;
            if (mem_read) got_rd++;
            if (mem_write) begin got_wr++; got_wdata = mem_wdata; end
            if (mem_read && mem_write) got_proto++;
            if (busy && mem_addr !== (a >> 2)) got_proto++;
            if (!busy) got_proto++;
            if (!done && (misaligned || access_fault)) got_proto++;
            if (done) begin
                got_lat = n; got_rdata = rdata; got_mis = misaligned; got_af = access_fault;
                req = 1'b0;
                break;
            end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++;
        if ({busy, done, misaligned, access_fault, mem_read, mem_write} !== 6'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=000000",
                            {busy, done, misaligned, access_fault, mem_read, mem_write});
        end
        total++;
        if ({rdata, mem_addr, mem_wdata} !== 96'd0) begin
            bad++; $display("FAIL reset_data rdata=%h mem_addr=%h mem_wdata=%h want all 0",
                            rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_store_word();
        run(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 1'b0);
        total++;
        if (got_lat !== 2 || got_wr !== 1 || got_rd !== 0 || got_wdata !== 32'hDEAD_BEEF ||
            got_proto !== 0) begin
            bad++; $display("FAIL sw lat=%0d wr=%0d rd=%0d wdata=%h proto=%0d want 2/1/0/deadbeef/0",
                            got_lat, got_wr, got_rd, got_wdata, got_proto);
        end
        run(1'b0, 3'b010, 32'h40, 32'd0, 1'b0);
        total++;
        if (got_lat !== 2 || got_rdata !== 32'hDEAD_BEEF || got_rd !== 1) begin
            bad++; $display("FAIL lw lat=%0d rdata=%h rd=%0d want 2/deadbeef/1",
                            got_lat, got_rdata, got_rd);
        end
    endtask

    task automatic test_subword_store();
        run(1'b1, 3'b000, 32'h41, 32'h1234_56AA, 1'b0);
        total++;
        if (got_lat !== 3 || got_rd !== 1 || got_wr !== 1 || got_wdata !== 32'hDEAD_AAEF ||
            got_proto !== 0) begin
            bad++; $display("FAIL sb lat=%0d rd=%0d wr=%0d wdata=%h proto=%0d want 3/1/1/deadaaef/0",
                            got_lat, got_rd, got_wr, got_wdata, got_proto);
        end
        run(1'b1, 3'b001, 32'h42, 32'h0000_CAFE, 1'b0);
        total++;
        if (got_lat !== 3 || got_wdata !== 32'hCAFE_AAEF) begin
            bad++; $display("FAIL sh lat=%0d wdata=%h want 3/cafeaaef", got_lat, got_wdata);
        end
        total++;
        if (tb_mem[16] !== 32'hCAFE_AAEF) begin
            bad++; $display("FAIL sh_mem got=%h want=cafeaaef", tb_mem[16]);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] as   [5] = '{32'h43, 32'h43, 32'h42, 32'h42, 32'h40};
        logic [31:0] want [5] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD,
                                  32'h0000_DEAD, 32'hFFFF_FFEF};
        run(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run(1'b0, f3s[i], as[i], 32'd0, 1'b0);
            total++;
            if (got_rdata !== want[i] || got_lat !== 2) begin
                bad++; $display("FAIL load_ext[%0d] f3=%b addr=%h rdata=%h lat=%0d want %h/2",
                                i, f3s[i], as[i], got_rdata, got_lat, want[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] as  [4] = '{32'h42, 32'h41, 32'h40, 32'h100};
        logic [1:0]  flg [4] = '{2'b10, 2'b10, 2'b10, 2'b01};
        logic [31:0] prev;
        for (int i = 0; i < 4; i++) begin
            prev = rdata;
            run(ws[i], f3s[i], as[i], 32'h7777_7777, 1'b0);
            total++;
            if (got_lat !== 1 || got_rd !== 0 || got_wr !== 0 || {got_mis, got_af} !== flg[i] ||
                got_rdata !== prev || got_proto !== 0) begin
                bad++; $display("FAIL err[%0d] lat=%0d rd=%0d wr=%0d flags=%b rdata=%h proto=%0d want 1/0/0/%b/%h/0",
                                i, got_lat, got_rd, got_wr, {got_mis, got_af}, got_rdata,
                                got_proto, flg[i], prev);
            end
        end
    endtask

    task automatic test_reset_abort();
        run(1'b1, 3'b010, 32'h44, 32'h1122_3344, 1'b0);
        req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h44; wdata = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        total++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            bad++; $display("FAIL rmw_rd_phase read=%b write=%b want 1/0", mem_read, mem_write);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, mem_read, mem_write} !== 4'd0) begin
            bad++; $display("FAIL abort got=%b want=0000", {busy, done, mem_read, mem_write});
        end
        ref_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (tb_mem[17] !== 32'h1122_3344) begin
            bad++; $display("FAIL abort_mem got=%h want=11223344", tb_mem[17]);
        end
        run(1'b0, 3'b010, 32'h44, 32'd0, 1'b0);
        total++;
        if (got_lat !== 2 || got_rdata !== 32'h1122_3344) begin
            bad++; $display("FAIL post_reset_lw lat=%0d rdata=%h want 2/11223344", got_lat, got_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int writes;
        int n_done;
        run(1'b1, 3'b010, 32'h80, 32'h0000_0055, 1'b0);
        run(1'b0, 3'b010, 32'h80, 32'd0, 1'b1);
        total++;
        if (got_rd !== 1 || got_lat !== 2 || got_rdata !== 32'h0000_0055) begin
            bad++; $display("FAIL held_req rd=%0d lat=%0d rdata=%h want 1/2/00000055",
                            got_rd, got_lat, got_rdata);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_done busy=%b want=0", busy);
        end
        ref_access(1'b0, 3'b010, 32'h80, 32'd0);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; addr = 32'h84; wdata = 32'hFFFF_FFFF;
        writes = 0; n_done = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            req = 1'b0;
            if (mem_write) writes++;
            if (done) n_done++;
        end
        total++;
        if (writes !== 0 || n_done !== 1 || tb_mem[33] !== ref_mem[33]) begin
            bad++; $display("FAIL dropped_req writes=%0d dones=%0d mem33=%h want 0/1/%h",
                            writes, n_done, tb_mem[33], ref_mem[33]);
        end
        run(1'b0, 3'b010, 32'h80, 32'd0, 1'b0);
        run(1'b0, 3'b000, 32'h80, 32'd0, 1'b0);
        total++;
        if (got_lat !== 2 || got_rdata !== 32'h0000_0055) begin
            bad++; $display("FAIL first_idle_accept lat=%0d rdata=%h want 2/00000055",
                            got_lat, got_rdata);
        end
    endtask

    task automatic test_random();
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        int          mem_bad;
        for (int i = 0; i < 120; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = {24'd0, 6'd0, 2'($urandom_range(0, 3))} | (32'($urandom_range(0, 71)) << 2);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            run(w, f3, a, $urandom, 1'b0);
            total++;
            if (got_lat !== exp_lat || got_rd !== exp_rd || got_wr !== exp_wr ||
                got_mis !== exp_mis || got_af !== exp_af || got_rdata !== exp_rdata ||
                (exp_wr == 1 && got_wdata !== exp_wdata) || got_proto !== 0) begin
                bad++; $display("FAIL rand[%0d] we=%b f3=%b a=%h got lat=%0d rd=%0d wr=%0d mis=%b af=%b rdata=%h wd=%h proto=%0d want %0d/%0d/%0d/%b/%b/%h/%h/0",
                                i, w, f3, a, got_lat, got_rd, got_wr, got_mis, got_af,
                                got_rdata, got_wdata, got_proto, exp_lat, exp_rd, exp_wr,
                                exp_mis, exp_af, exp_rdata, exp_wdata);
            end
        end
        mem_bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (tb_mem[i] !== ref_mem[i]) mem_bad++;
        total++;
        if (mem_bad != 0) begin
            bad++; $display("FAIL mem_image mismatched_words=%0d want=0", mem_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
        ref_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);
        test_store_word();
        test_subword_store();
        test_load_extend();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
